// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch buffer: issues pipelined fetches for the core, tracks in-flight
// addresses and returns parcels in order, dropping responses that belong to a flushed stream.
module riscv_if_prefetch #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PC_INIT     = 'h200,
  parameter int              PARCEL_SIZE = 32,
  parameter int              DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [XLEN-1:0]            if_nxt_pc_i,
  input  logic                       if_stall_i,
  input  logic                       if_flush_i,
  output logic                       if_stall_nxt_pc_o,
  output logic [PARCEL_SIZE-1:0]     if_parcel_o,
  output logic [XLEN-1:0]            if_parcel_pc_o,
  output logic [PARCEL_SIZE/16-1:0]  if_parcel_valid_o,
  output logic                       if_parcel_misaligned_o,
  output logic                       if_parcel_page_fault_o,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_adr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_ack_i,
  input  logic [PARCEL_SIZE-1:0]     imem_q_i,
  input  logic                       imem_err_i,
  input  logic                       imem_misaligned_i,
  input  logic                       imem_page_fault_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;
  localparam logic [PARCEL_SIZE-1:0] NOP_PARCEL = PARCEL_SIZE'(32'h0000_0013);

  logic [PARCEL_SIZE-1:0] fifo_parcel_r [DEPTH];
  logic [XLEN-1:0]        fifo_pc_r     [DEPTH];
  logic [XLEN-1:0]        aq_pc_r       [DEPTH];
  logic [DEPTH-1:0]       fifo_mis_r, fifo_pf_r;
  logic [PW-1:0]          fifo_wr_r, fifo_rd_r, aq_wr_r, aq_rd_r, aq_wr_idx_s;
  logic [CW-1:0]          fifo_cnt_r, outstanding_r, discard_r;
  logic [CW-1:0]          fifo_cnt_nxt_s, outstanding_nxt_s, discard_nxt_s;
  logic [SW-1:0]          used_s, flush_pend_s;
  logic                   slot_s, accept_s, stale_ack_s, live_ack_s, fifo_pop_s;

  // slot availability, request handshake and response classification
  always_comb begin
    used_s      = SW'(fifo_cnt_r) + SW'(outstanding_r) + SW'(discard_r);
    slot_s      = (used_s < SW'(DEPTH));
    accept_s    = slot_s & imem_gnt_i;
    stale_ack_s = imem_ack_i & (if_flush_i | (discard_r != '0));
    live_ack_s  = imem_ack_i & ~stale_ack_s;
    fifo_pop_s  = (fifo_cnt_r != '0) & ~if_stall_i & ~if_flush_i;
    aq_wr_idx_s = if_flush_i ? '0 : aq_wr_r;
  end

  assign imem_req_o        = slot_s;
  assign imem_adr_o        = if_nxt_pc_i;
  assign if_stall_nxt_pc_o = ~accept_s;

  // next values of the occupancy counters; a flush turns everything in flight into discards
  always_comb begin
    fifo_cnt_nxt_s    = fifo_cnt_r;
    outstanding_nxt_s = outstanding_r;
    discard_nxt_s     = discard_r;
    flush_pend_s      = SW'(discard_r) + SW'(outstanding_r);
    if (if_flush_i) begin
      fifo_cnt_nxt_s    = '0;
      outstanding_nxt_s = accept_s ? CW'(1) : '0;
      if (imem_ack_i && (flush_pend_s != '0)) begin
        discard_nxt_s = CW'(flush_pend_s - SW'(1));
      end else if (imem_ack_i) begin
        discard_nxt_s = '0;
      end else begin
        discard_nxt_s = CW'(flush_pend_s);
      end
    end else begin
      fifo_cnt_nxt_s    = fifo_cnt_r + CW'(live_ack_s) - CW'(fifo_pop_s);
      outstanding_nxt_s = outstanding_r + CW'(accept_s) - CW'(live_ack_s);
      if (stale_ack_s) begin
        discard_nxt_s = discard_r - CW'(1);
      end else begin
        discard_nxt_s = discard_r;
      end
    end
  end

  // occupancy counters and ring pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt_r    <= '0;
      outstanding_r <= '0;
      discard_r     <= '0;
      fifo_wr_r     <= '0;
      fifo_rd_r     <= '0;
      aq_wr_r       <= '0;
      aq_rd_r       <= '0;
    end else begin
      fifo_cnt_r    <= fifo_cnt_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      if (if_flush_i) begin
        fifo_wr_r <= '0;
        fifo_rd_r <= '0;
        aq_rd_r   <= '0;
        aq_wr_r   <= accept_s ? PW'(1) : '0;
      end else begin
        if (live_ack_s) fifo_wr_r <= fifo_wr_r + PW'(1);
        if (fifo_pop_s) fifo_rd_r <= fifo_rd_r + PW'(1);
        if (accept_s)   aq_wr_r   <= aq_wr_r + PW'(1);
        if (live_ack_s) aq_rd_r   <= aq_rd_r + PW'(1);
      end
    end
  end

  // in-flight address queue and parcel storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        aq_pc_r[i]       <= '0;
        fifo_parcel_r[i] <= '0;
        fifo_pc_r[i]     <= '0;
      end
      fifo_mis_r <= '0;
      fifo_pf_r  <= '0;
    end else begin
      if (accept_s) aq_pc_r[aq_wr_idx_s] <= if_nxt_pc_i;
      if (live_ack_s) begin
        fifo_parcel_r[fifo_wr_r] <= imem_q_i;
        fifo_pc_r[fifo_wr_r]     <= aq_pc_r[aq_rd_r];
        fifo_mis_r[fifo_wr_r]    <= imem_misaligned_i;
        fifo_pf_r[fifo_wr_r]     <= imem_page_fault_i | imem_err_i;
      end
    end
  end

  // head presentation; an empty buffer shows a NOP at pc 0
  always_comb begin
    if (fifo_cnt_r != '0) begin
      if_parcel_o            = fifo_parcel_r[fifo_rd_r];
      if_parcel_pc_o         = fifo_pc_r[fifo_rd_r];
      if_parcel_valid_o      = '1;
      if_parcel_misaligned_o = fifo_mis_r[fifo_rd_r];
      if_parcel_page_fault_o = fifo_pf_r[fifo_rd_r];
    end else begin
      if_parcel_o            = NOP_PARCEL;
      if_parcel_pc_o         = '0;
      if_parcel_valid_o      = '0;
      if_parcel_misaligned_o = 1'b0;
      if_parcel_page_fault_o = 1'b0;
    end
  end

  riscv_if_prefetch_chk #(.XLEN(XLEN), .PC_INIT(PC_INIT), .DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fifo_cnt      (fifo_cnt_r),
    .outstanding   (outstanding_r),
    .discard       (discard_r),
    .live_ack      (live_ack_s)
  );
endmodule

// Occupancy and configuration invariants of the prefetch buffer.
module riscv_if_prefetch_chk #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200,
  parameter int              DEPTH   = 4,
  parameter int              CW      = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic [CW-1:0] fifo_cnt,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] discard,
  input logic          live_ack
);
  a_fifo_cnt_max:    assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_cnt <= CW'(DEPTH));
  a_outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_ni) outstanding <= CW'(DEPTH));
  a_discard_max:     assert property (@(posedge clk_i) disable iff (!rst_ni) discard <= CW'(DEPTH));
  a_ack_has_req:     assert property (@(posedge clk_i) disable iff (!rst_ni) live_ack |-> (outstanding != '0));
  a_depth_pow2:      assert property (@(posedge clk_i) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
  a_pc_init_align:   assert property (@(posedge clk_i) PC_INIT[0] == 1'b0);
endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Self-checking bench for riscv_if_prefetch: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_riscv_if_prefetch;
  localparam int XLEN = 32;
  localparam int PS = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [XLEN-1:0] nxt_pc;
  logic stall, flush, snp, req, gnt, ack, err, mis, pf, p_mis, p_pf;
  logic [PS-1:0] parcel, q;
  logic [XLEN-1:0] p_pc, adr;
  logic [PS/16-1:0] p_vld;

  always #5 clk = ~clk;

  riscv_if_prefetch #(.XLEN(XLEN), .PC_INIT(32'h200), .PARCEL_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .if_nxt_pc_i(nxt_pc), .if_stall_i(stall), .if_flush_i(flush),
    .if_stall_nxt_pc_o(snp), .if_parcel_o(parcel), .if_parcel_pc_o(p_pc), .if_parcel_valid_o(p_vld),
    .if_parcel_misaligned_o(p_mis), .if_parcel_page_fault_o(p_pf), .imem_req_o(req), .imem_adr_o(adr),
    .imem_gnt_i(gnt), .imem_ack_i(ack), .imem_q_i(q), .imem_err_i(err), .imem_misaligned_i(mis),
    .imem_page_fault_i(pf)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string t, input logic e_req, input logic e_snp);
    chk({t, "_req"}, 64'(req), 64'(e_req));
    chk({t, "_stall_nxt_pc"}, 64'(snp), 64'(e_snp));
  endtask

  task automatic chk_head(input string t, input logic v, input logic [31:0] par,
                          input logic [31:0] a, input logic e_mis, input logic e_pf);
    chk({t, "_valid"}, 64'(p_vld), v ? 64'h3 : 64'h0);
    chk({t, "_parcel"}, 64'(parcel), v ? 64'(par) : 64'h13);
    chk({t, "_pc"}, 64'(p_pc), v ? 64'(a) : 64'h0);
    chk({t, "_mis"}, 64'(p_mis), v ? 64'(e_mis) : 64'h0);
    chk({t, "_pf"}, 64'(p_pf), v ? 64'(e_pf) : 64'h0);
  endtask

  task automatic drive(input logic g, input logic [31:0] a, input logic k, input logic [31:0] apc,
                       input logic e, input logic m, input logic f, input logic s, input logic fl);
    gnt = g; nxt_pc = a; ack = k; q = k ? data_of(apc) : 32'h0;
    err = k & e; mis = k & m; pf = k & f; stall = s; flush = fl;
  endtask

  // drive a cycle's inputs and move to the sampling point (negedge)
  task automatic cyc(input logic g, input logic [31:0] a, input logic k, input logic [31:0] apc,
                     input logic s, input logic fl);
    drive(g, a, k, apc, 1'b0, 1'b0, 1'b0, s, fl);
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_bus("rst_g1", 1'b1, 1'b0);
    chk_head("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    gnt = 1'b0;
    #1;
    chk_bus("rst_g0", 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic gnt; logic [31:0] pc; logic ack; logic [31:0] apc; logic err; logic mis;
    logic req; logic snp; logic vld; logic [31:0] hpc; logic hpf; logic hmis;
  } vec_t;

  typedef struct { logic [31:0] pc; int gcyc; bit stale; } fl_t;
  typedef struct { logic [31:0] parcel; logic [31:0] pc; logic mis; logic pf; } ent_t;

  vec_t tbl[8];
  fl_t infl[$];
  ent_t bufq[$];

  initial begin
    fl_t fe;
    ent_t ee;
    logic g, s, fl, k, e, m, f, e_req, acc, pop;
    logic [31:0] core_pc, apc;

    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // streaming with 1-cycle ack, fault tagging on 'h208 (err) and 'h20c (misaligned)
    tbl[0] = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h204, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h208, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h20c, 1'b1, 32'h208, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'h210, 1'b1, 32'h20c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h208, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'h214, 1'b1, 32'h210, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20c, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h214, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h210, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'h214, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].gnt, tbl[i].pc, tbl[i].ack, tbl[i].apc, tbl[i].err, tbl[i].mis, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("tbl_adr", 64'(adr), 64'(tbl[i].pc));
      chk_bus($sformatf("tbl%0d", i), tbl[i].req, tbl[i].snp);
      chk_head($sformatf("tbl%0d", i), tbl[i].vld, data_of(tbl[i].hpc), tbl[i].hpc, tbl[i].hmis, tbl[i].hpf);
      tick();
    end

    // full buffer: core stalled, four accepts fill every slot
    do_reset();
    cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0);   tick();
    cyc(1'b1, 32'h204, 1'b1, 32'h200, 1'b1, 1'b0); tick();
    cyc(1'b1, 32'h208, 1'b1, 32'h204, 1'b1, 1'b0); tick();
    cyc(1'b1, 32'h20c, 1'b1, 32'h208, 1'b1, 1'b0); chk_bus("full_c3", 1'b1, 1'b0); tick();
    cyc(1'b1, 32'h210, 1'b1, 32'h20c, 1'b1, 1'b0); chk_bus("full_c4", 1'b0, 1'b1); tick();
    cyc(1'b1, 32'h210, 1'b0, 32'h0, 1'b1, 1'b0);   chk_bus("full_c5", 1'b0, 1'b1); tick();
    cyc(1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 1'b0);   chk_bus("full_pop", 1'b0, 1'b1);
    chk_head("full_pop", 1'b1, data_of(32'h200), 32'h200, 1'b0, 1'b0); tick();
    cyc(1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 1'b0);   chk_bus("full_after", 1'b1, 1'b0);
    chk_head("full_after", 1'b1, data_of(32'h204), 32'h204, 1'b0, 1'b0); tick();

    // flush with three requests in flight (ack latency 3), new stream granted in the flush cycle
    do_reset();
    cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);   tick();
    cyc(1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 1'b0);   tick();
    cyc(1'b1, 32'h208, 1'b0, 32'h0, 1'b0, 1'b0);   tick();
    cyc(1'b1, 32'h400, 1'b1, 32'h200, 1'b0, 1'b1); chk_bus("fl_f", 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h404, 1'b1, 32'h204, 1'b0, 1'b0); chk_bus("fl_f1", 1'b1, 1'b1);
    chk_head("fl_f1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h404, 1'b1, 32'h208, 1'b0, 1'b0); chk_head("fl_f2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h404, 1'b1, 32'h400, 1'b0, 1'b0); chk_head("fl_f3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h404, 1'b0, 32'h0, 1'b0, 1'b0);   chk_head("fl_new", 1'b1, data_of(32'h400), 32'h400, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h404, 1'b0, 32'h0, 1'b0, 1'b0);   chk_head("fl_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();

    // grant backpressure 1,0,0,1: address is held until accepted, never duplicated
    do_reset();
    cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);   chk_bus("gb0", 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h204, 1'b1, 32'h200, 1'b0, 1'b0); chk_bus("gb1", 1'b1, 1'b1); tick();
    cyc(1'b0, 32'h204, 1'b0, 32'h0, 1'b0, 1'b0);   chk_bus("gb2", 1'b1, 1'b1);
    chk_head("gb2", 1'b1, data_of(32'h200), 32'h200, 1'b0, 1'b0); tick();
    cyc(1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 1'b0);   chk_bus("gb3", 1'b1, 1'b0);
    chk_head("gb3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h208, 1'b1, 32'h204, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h208, 1'b0, 32'h0, 1'b0, 1'b0);   chk_head("gb5", 1'b1, data_of(32'h204), 32'h204, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h208, 1'b0, 32'h0, 1'b0, 1'b0);   chk_head("gb6", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();

    // reset while two parcels are buffered, then restart from a new address
    do_reset();
    cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0);   tick();
    cyc(1'b1, 32'h204, 1'b1, 32'h200, 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h208, 1'b1, 32'h204, 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h208, 1'b0, 32'h0, 1'b1, 1'b0);   chk_head("mr_pre", 1'b1, data_of(32'h200), 32'h200, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_head("mr_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_bus("mr_rst", 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    cyc(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);   chk_head("mr_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h304, 1'b1, 32'h300, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0);   chk_head("mr_new", 1'b1, data_of(32'h300), 32'h300, 1'b0, 1'b0); tick();

    // random traffic against the queue model
    do_reset();
    infl.delete();
    bufq.delete();
    core_pc = 32'h200;
    for (int c = 0; c < 3000; c++) begin
      g  = ($urandom_range(3) != 0);
      s  = ($urandom_range(3) == 0);
      fl = ($urandom_range(19) == 0);
      if (fl) core_pc = {16'h0, 14'($urandom_range(16383)), 2'b00};
      k = 1'b0;
      apc = 32'h0;
      if (infl.size() > 0 && infl[0].gcyc < c && $urandom_range(9) < 7) begin
        k = 1'b1;
        apc = infl[0].pc;
      end
      e = ($urandom_range(9) == 0);
      m = ($urandom_range(9) == 0);
      f = ($urandom_range(9) == 0);
      drive(g, core_pc, k, apc, e, m, f, s, fl);
      @(negedge clk);
      e_req = ((bufq.size() + infl.size()) < DEPTH);
      chk("rnd_adr", 64'(adr), 64'(core_pc));
      chk_bus("rnd", e_req, ~(e_req & g));
      if (bufq.size() > 0) chk_head("rnd", 1'b1, bufq[0].parcel, bufq[0].pc, bufq[0].mis, bufq[0].pf);
      else chk_head("rnd", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      acc = e_req & g;
      pop = (bufq.size() > 0) && !s && !fl;
      if (pop) void'(bufq.pop_front());
      if (k) begin
        fe = infl.pop_front();
        if (!fe.stale && !fl) begin
          ee.parcel = data_of(fe.pc); ee.pc = fe.pc; ee.mis = m; ee.pf = f | e;
          bufq.push_back(ee);
        end
      end
      if (fl) begin
        bufq.delete();
        foreach (infl[j]) infl[j].stale = 1'b1;
      end
      if (acc) begin
        fe.pc = core_pc; fe.gcyc = c; fe.stale = 1'b0;
        infl.push_back(fe);
        core_pc = core_pc + 32'h4;
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_if_prefetch.md
# riscv_if_prefetch

Instruction prefetch buffer between the core's instruction-fetch port and the instruction memory bus. The core supplies the next fetch address. This block issues pipelined requests, tracks in-flight addresses, and buffers returned parcels in order. It drives the core's `if_parcel*` inputs, discards stale responses on flush, and backpressures the core through `if_stall_nxt_pc`.

## Interface
- `XLEN`, 32, data/address width.
- `PC_INIT`, 'h200, reset fetch address (informational; the core drives addresses).
- `PARCEL_SIZE`, 32, parcel width; `if_parcel_valid_o` width is `PARCEL_SIZE/16`.
- `DEPTH`, 4, buffer entries and maximum in-flight requests (power of two, ≥2).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `if_nxt_pc_i` in XLEN: fetch address from the core.
- `if_stall_i` in 1: core holds the head parcel; no pop.
- `if_flush_i` in 1: discard buffered and in-flight parcels.
- `if_stall_nxt_pc_o` out 1: request not accepted this cycle; the core holds `if_nxt_pc_i`.
- `if_parcel_o` out PARCEL_SIZE: head parcel.
- `if_parcel_pc_o` out XLEN: address of the head parcel.
- `if_parcel_valid_o` out PARCEL_SIZE/16: all ones when the head is valid, else 0.
- `if_parcel_misaligned_o`, `if_parcel_page_fault_o` out 1 each: head fault flags.
- `imem_req_o` out 1: request strobe.
- `imem_adr_o` out XLEN: request address, equal to `if_nxt_pc_i`.
- `imem_gnt_i` in 1: the bus accepts the request in this cycle when `imem_req_o` is high.
- `imem_ack_i` in 1: in-order response valid.
- `imem_q_i` in PARCEL_SIZE: response data.
- `imem_err_i`, `imem_misaligned_i`, `imem_page_fault_i` in 1 each: response status, sampled with `imem_ack_i`.

## Operation
- **State:**
  - Parcel FIFO of DEPTH entries; each entry holds parcel, pc, misaligned and page_fault.
  - Address queue of DEPTH entries holding in-flight request PCs.
  - `outstanding` counter, 0..DEPTH.
  - `discard` counter, 0..DEPTH.
  - `fifo_cnt` counter, 0..DEPTH.
- **Slot rule:** `slot = (fifo_cnt + outstanding + discard) < DEPTH`. A pop in the same cycle does not free a slot until the next cycle.
- **Request:**
  - `imem_req_o = slot`.
  - Accepted when `imem_req_o & imem_gnt_i`: push `if_nxt_pc_i` into the address queue and increment `outstanding`.
  - `if_stall_nxt_pc_o = ~(imem_req_o & imem_gnt_i)`.
- **Response (`imem_ack_i`):**
  - If `discard > 0`: decrement `discard`; data is dropped and the address queue is untouched.
  - Otherwise: pop the address queue, decrement `outstanding`, and push the FIFO entry {`imem_q_i`, popped pc, `imem_misaligned_i`, `imem_page_fault_i | imem_err_i`}.
  - A response never overflows the FIFO, guaranteed by the slot rule.
- **Pop:** when `fifo_cnt>0 & ~if_stall_i & ~if_flush_i`.
- **Flush (`if_flush_i`):**
  - Next-cycle values: `fifo_cnt=0`, address queue emptied, `outstanding=0`.
  - `discard` next = `discard + outstanding − (ack this cycle)`, saturating at 0.
  - A request accepted in the flush cycle belongs to the new stream: it is pushed to the emptied queue with `outstanding=1`.
  - An ack in the flush cycle is treated as stale.
- **Outputs:**
  - When `fifo_cnt>0`: head entry fields, and `if_parcel_valid_o` all ones.
  - When empty: `if_parcel_o = 'h0000_0013` (NOP), `if_parcel_pc_o = 0`, flags 0, valid 0.
- **Simultaneous events:**
  - Push and pop in the same cycle: `fifo_cnt` unchanged.
  - Request accept and non-discarded ack in the same cycle: `outstanding` unchanged.
- **Bus error:** an error response does not stop fetching; the fault is reported on that parcel only.

## Timing
- Reset values:
  - All counters 0.
  - `if_parcel_valid_o=0`, `if_parcel_o='h13`, `if_parcel_pc_o=0`, fault flags 0.
  - `imem_req_o=1`; `if_stall_nxt_pc_o = ~imem_gnt_i`.
- Reset mid-operation clears all state immediately. Responses arriving after reset deassertion for pre-reset requests are the bus's responsibility (the bus is reset together with this block).
- Request-to-response latency: earliest ack in cycle N+1 for a grant in cycle N; a grant-and-ack in the same cycle for the same request is illegal.
- Ack in cycle M → parcel visible on `if_parcel_*` in cycle M+1; no combinational bypass.
- Flush in cycle F → `if_parcel_valid_o=0` in cycle F+1. The first new-stream parcel appears no earlier than F+2.
- Sustained throughput is one parcel per cycle when `imem_gnt_i=1`, ack latency is 1, and DEPTH≥2.
- Counter arithmetic uses `$clog2(DEPTH)+1` bits; no wrap is allowed, so assertions check `fifo_cnt`, `outstanding` and `discard` ≤ DEPTH.

## Test plan
- **Streaming:** gnt=1, 1-cycle ack, addresses 'h200, 'h204, 'h208 … → parcels appear in order, each with matching pc, one per cycle after a 2-cycle initial latency.
- **Full buffer:** DEPTH=4, `if_stall_i=1` held, ack latency 1 → after 4 accepts, `imem_req_o=0` and `if_stall_nxt_pc_o=1`. Releasing the stall pops 'h200 first, and the next request issues one cycle after the first pop.
- **Flush with in-flight requests:** 3 requests outstanding with ack latency 3, flush asserted with `if_nxt_pc_i='h400` granted in the flush cycle → the 3 stale acks are dropped and the first visible parcel has pc 'h400.
- **Fault tagging:** ack with `imem_err_i=1` for 'h208 → that parcel has `if_parcel_page_fault_o=1`; neighbouring parcels have 0. `imem_misaligned_i` propagates likewise.
- **Grant backpressure:** `imem_gnt_i` toggling 1,0,0,1 → `if_stall_nxt_pc_o` follows ~gnt, and no address is duplicated or skipped in the address queue.
- **Mid-operation reset:** `rst_ni` low while 2 parcels are buffered → outputs return to reset values in the same cycle; after release, fetch restarts from the address the core presents.
